// File: rtl/spram_arbiter.sv
// Two-client round-robin arbiter in front of a single-port SRAM.
// Each cycle it accepts at most one request and registers it into the SRAM
// issue stage. A {valid, owner} tag follows each read, so the read data goes
// back to the client that asked for it two cycles after acceptance.
module spram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Identifies a client. Used for the round-robin history and for the read tags.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t              last_grant;
    logic                grant_a;
    logic                grant_b;
    logic                accept;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    logic                tag1_valid;
    grant_t              tag1_owner;
    logic                tag2_valid;
    grant_t              tag2_owner;

    logic [DATA_W-1:0]   a_rdata_hold;
    logic [DATA_W-1:0]   b_rdata_hold;

    // Decide who is ready. A lone requester always wins. When both request,
    // the client that was not granted last wins. Nobody is ready while reset is high.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset) begin
            if (a_valid && (!b_valid || last_grant == GRANT_B))
                a_ready = 1'b1;
            if (b_valid && (!a_valid || last_grant == GRANT_A))
                b_ready = 1'b1;
        end
    end

    // Select the accepted transfer. A client's inputs are only looked at here.
    always_comb begin
        grant_a   = a_valid && a_ready;
        grant_b   = b_valid && b_ready;
        accept    = grant_a || grant_b;
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (grant_b) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    // Round-robin history. It moves only when a transfer is actually accepted.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= GRANT_B;
        else if (accept)
            last_grant <= grant_b ? GRANT_B : GRANT_A;
    end

    // SRAM issue stage. The write enable pulses once per accepted write.
    // Address and data hold their values on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_we <= accept && sel_we;
            if (accept) begin
                ram_addr <= sel_addr;
                ram_din  <= sel_wdata;
            end
        end
    end

    // Read tag pipeline. The tag is in stage 1 while the SRAM sees the address,
    // and in stage 2 while the SRAM presents the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag1_valid <= 1'b0;
            tag1_owner <= GRANT_A;
            tag2_valid <= 1'b0;
            tag2_owner <= GRANT_A;
        end else begin
            tag1_valid <= accept && !sel_we;
            tag1_owner <= grant_b ? GRANT_B : GRANT_A;
            tag2_valid <= tag1_valid;
            tag2_owner <= tag1_owner;
        end
    end

    // Read data passes straight through on the return cycle. A copy is kept
    // so each client sees its last value while its rvalid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata_hold <= '0;
            b_rdata_hold <= '0;
        end else begin
            if (a_rvalid)
                a_rdata_hold <= ram_dout;
            if (b_rvalid)
                b_rdata_hold <= ram_dout;
        end
    end

    assign a_rvalid = tag2_valid && (tag2_owner == GRANT_A);
    assign b_rvalid = tag2_valid && (tag2_owner == GRANT_B);
    assign a_rdata  = a_rvalid ? ram_dout : a_rdata_hold;
    assign b_rdata  = b_rvalid ? ram_dout : b_rdata_hold;

endmodule
